alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU (3-bit command: ADD=0, SUB=1, XOR=2, SLT=3, AND=4, NAND=5, NOR=6, OR=7) between two requesters using valid/ready handshakes.
- Arbitrates round-robin and registers the winner's operands and command, then drives the ALU from those registers.
- Captures result and flags one cycle later and holds them on a single response channel, tagged with the requester id, until accepted.
- Sits between the two issuing units and the ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 25 ++
 rtl/alu_arbiter_if.sv | 53 +++++
 rtl/alu_arbiter_rr_arb2.sv | 19 +
 rtl/alu_arbiter.sv | 103 ++++++++++
 tb/tb_alu_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: ALU command codes,
// FSM state encodings and a small id helper.
package alu_arbiter_pkg;

    localparam logic [2:0] CMD_ADD  = 3'd0;
    localparam logic [2:0] CMD_SUB  = 3'd1;
    localparam logic [2:0] CMD_XOR  = 3'd2;
    localparam logic [2:0] CMD_SLT  = 3'd3;
    localparam logic [2:0] CMD_AND  = 3'd4;
    localparam logic [2:0] CMD_NAND = 3'd5;
    localparam logic [2:0] CMD_NOR  = 3'd6;
    localparam logic [2:0] CMD_OR   = 3'd7;

    // Encoding 2'd3 is unused; the FSM treats it as IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic other_id(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of both request channels, the response channel and the ALU-side
// signals. The arbiter uses the slave view; the surrounding system the master view.
interface alu_arbiter_if #(parameter int WIDTH = 32);

    logic             r0_valid;
    logic             r0_ready;
    logic [WIDTH-1:0] r0_a;
    logic [WIDTH-1:0] r0_b;
    logic [2:0]       r0_cmd;

    logic             r1_valid;
    logic             r1_ready;
    logic [WIDTH-1:0] r1_a;
    logic [WIDTH-1:0] r1_b;
    logic [2:0]       r1_cmd;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_carryout;
    logic             rsp_zero;
    logic             rsp_overflow;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [2:0]       alu_cmd;
    logic [WIDTH-1:0] alu_result;
    logic             alu_carryout;
    logic             alu_zero;
    logic             alu_overflow;

    modport slave (
        input  r0_valid, r0_a, r0_b, r0_cmd,
        input  r1_valid, r1_a, r1_b, r1_cmd,
        output r0_ready, r1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
        input  rsp_ready,
        output alu_a, alu_b, alu_cmd,
        input  alu_result, alu_carryout, alu_zero, alu_overflow
    );

    modport master (
        output r0_valid, r0_a, r0_b, r0_cmd,
        output r1_valid, r1_a, r1_b, r1_cmd,
        input  r0_ready, r1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carryout, rsp_zero, rsp_overflow,
        output rsp_ready,
        input  alu_a, alu_b, alu_cmd,
        output alu_result, alu_carryout, alu_zero, alu_overflow
    );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin grant: priority holder wins a tie, a lone requester
// always wins. Purely combinational.
module rr_arb2
    import alu_arbiter_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       prio,
    output logic [1:0] grant,
    output logic       next_prio
);

    for (genvar gi = 0; gi < 2; gi++) begin : g_grant
        assign grant[gi] = valid[gi] && (!valid[1-gi] || (prio == 1'(gi)));
    end

    // After a grant the other requester takes priority; otherwise keep it.
    assign next_prio = (|grant) ? other_id(grant[1]) : prio;

endmodule

// File: rtl/alu_arbiter.sv
// Shares one external combinational ALU between two valid/ready requesters:
// accept -> drive registered operands for one cycle -> hold tagged response.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter bit RR_INIT = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    state_t           state_reg, state_next;
    logic             prio_reg;
    logic             id_reg;
    logic [WIDTH-1:0] alu_a_reg, alu_b_reg;
    logic [2:0]       alu_cmd_reg;
    logic             rsp_valid_reg, rsp_id_reg;
    logic [WIDTH-1:0] rsp_result_reg;
    logic             rsp_carryout_reg, rsp_zero_reg, rsp_overflow_reg;

    logic [1:0] grant;
    logic       prio_next;
    logic       in_idle;
    logic       accept;

    rr_arb2 u_rr_arb2 (
        .valid     ({bus.r1_valid, bus.r0_valid}),
        .prio      (prio_reg),
        .grant     (grant),
        .next_prio (prio_next)
    );

    assign in_idle      = (state_reg == ST_IDLE);
    assign accept       = in_idle && (|grant);
    assign bus.r0_ready = in_idle && grant[0];
    assign bus.r1_ready = in_idle && grant[1];
    assign busy         = !in_idle;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (accept) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_valid_reg && bus.rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prio_reg         <= RR_INIT;
            id_reg           <= 1'b0;
            alu_a_reg        <= '0;
            alu_b_reg        <= '0;
            alu_cmd_reg      <= '0;
            rsp_valid_reg    <= 1'b0;
            rsp_id_reg       <= 1'b0;
            rsp_result_reg   <= '0;
            rsp_carryout_reg <= 1'b0;
            rsp_zero_reg     <= 1'b0;
            rsp_overflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: if (accept) begin
                    id_reg      <= grant[1];
                    prio_reg    <= prio_next;
                    alu_a_reg   <= grant[1] ? bus.r1_a   : bus.r0_a;
                    alu_b_reg   <= grant[1] ? bus.r1_b   : bus.r0_b;
                    alu_cmd_reg <= grant[1] ? bus.r1_cmd : bus.r0_cmd;
                end
                ST_EXEC: begin
                    rsp_valid_reg    <= 1'b1;
                    rsp_id_reg       <= id_reg;
                    rsp_result_reg   <= bus.alu_result;
                    rsp_carryout_reg <= bus.alu_carryout;
                    rsp_zero_reg     <= bus.alu_zero;
                    rsp_overflow_reg <= bus.alu_overflow;
                end
                ST_RESP: if (bus.rsp_ready) rsp_valid_reg <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.alu_a        = alu_a_reg;
    assign bus.alu_b        = alu_b_reg;
    assign bus.alu_cmd      = alu_cmd_reg;
    assign bus.rsp_valid    = rsp_valid_reg;
    assign bus.rsp_id       = rsp_id_reg;
    assign bus.rsp_result   = rsp_result_reg;
    assign bus.rsp_carryout = rsp_carryout_reg;
    assign bus.rsp_zero     = rsp_zero_reg;
    assign bus.rsp_overflow = rsp_overflow_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: table of single-requester ops, then
// reset-in-EXEC, round-robin alternation, response stall and r1-only runs.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    logic busy;

    alu_arbiter_if #(.WIDTH(W)) bus ();

    alu_arbiter #(.WIDTH(W), .RR_INIT(1'b0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags only for ADD/SUB, SLT gives 0/1 with flags 0.
    logic [W:0] ext;
    always_comb begin
        ext              = '0;
        bus.alu_result   = '0;
        bus.alu_carryout = 1'b0;
        bus.alu_zero     = 1'b0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_cmd)
            CMD_ADD: begin
                ext              = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
                bus.alu_result   = ext[W-1:0];
                bus.alu_carryout = ext[W];
                bus.alu_zero     = (ext[W-1:0] == '0);
                bus.alu_overflow = (bus.alu_a[W-1] == bus.alu_b[W-1]) && (ext[W-1] != bus.alu_a[W-1]);
            end
            CMD_SUB: begin
                ext              = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 33'd1;
                bus.alu_result   = ext[W-1:0];
                bus.alu_carryout = ext[W];
                bus.alu_zero     = (ext[W-1:0] == '0);
                bus.alu_overflow = (bus.alu_a[W-1] != bus.alu_b[W-1]) && (ext[W-1] != bus.alu_a[W-1]);
            end
            CMD_XOR:  bus.alu_result = bus.alu_a ^ bus.alu_b;
            CMD_SLT:  bus.alu_result = {{(W-1){1'b0}}, ($signed(bus.alu_a) < $signed(bus.alu_b))};
            CMD_AND:  bus.alu_result = bus.alu_a & bus.alu_b;
            CMD_NAND: bus.alu_result = ~(bus.alu_a & bus.alu_b);
            CMD_NOR:  bus.alu_result = ~(bus.alu_a | bus.alu_b);
            CMD_OR:   bus.alu_result = bus.alu_a | bus.alu_b;
            default:  ;
        endcase
    end

    typedef struct {
        bit          id;
        logic [2:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          c;
        bit          z;
        bit          o;
    } vec_t;

    vec_t vecs[10];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input bit id, input logic [2:0] cmd, input logic [31:0] a, input logic [31:0] b);
        if (id) begin
            bus.r1_valid = 1'b1; bus.r1_cmd = cmd; bus.r1_a = a; bus.r1_b = b;
        end else begin
            bus.r0_valid = 1'b1; bus.r0_cmd = cmd; bus.r0_a = a; bus.r0_b = b;
        end
    endtask

    // Called at a falling edge with the arbiter idle; returns at a falling edge idle.
    task automatic run_vec(input vec_t v);
        drive(v.id, v.cmd, v.a, v.b);
        #1;
        check("ready_idle", v.id ? bus.r1_ready : bus.r0_ready, 1);
        check("other_ready_low", v.id ? bus.r0_ready : bus.r1_ready, 0);
        @(negedge clk);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        check("exec_busy", busy, 1);
        check("exec_rsp_valid", bus.rsp_valid, 0);
        check("alu_a", bus.alu_a, v.a);
        check("alu_cmd", bus.alu_cmd, v.cmd);
        @(negedge clk);
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_id", bus.rsp_id, v.id);
        check("rsp_result", bus.rsp_result, v.res);
        check("rsp_carryout", bus.rsp_carryout, v.c);
        check("rsp_zero", bus.rsp_zero, v.z);
        check("rsp_overflow", bus.rsp_overflow, v.o);
        $display("op id=%0d cmd=%0d a=%h b=%h result=%h c=%0d z=%0d o=%0d",
                 v.id, v.cmd, v.a, v.b, bus.rsp_result, bus.rsp_carryout, bus.rsp_zero, bus.rsp_overflow);
        @(negedge clk);
        check("back_idle", busy, 0);
        check("rsp_dropped", bus.rsp_valid, 0);
    endtask

    initial begin
        vecs[0] = '{0, CMD_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 0, 0, 1};
        vecs[1] = '{1, CMD_SUB,  32'h00000005, 32'h00000005, 32'h00000000, 1, 1, 0};
        vecs[2] = '{0, CMD_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0};
        vecs[3] = '{1, CMD_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0};
        vecs[4] = '{0, CMD_NAND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 0, 0, 0};
        vecs[5] = '{1, CMD_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0};
        vecs[6] = '{0, CMD_NOR,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 0, 0, 0};
        vecs[7] = '{1, CMD_SLT,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 0, 0, 0};
        vecs[8] = '{0, CMD_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1, 0};
        vecs[9] = '{1, CMD_SUB,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 1};

        reset = 1'b1;
        bus.r0_valid = 1'b0; bus.r0_a = '0; bus.r0_b = '0; bus.r0_cmd = '0;
        bus.r1_valid = 1'b0; bus.r1_a = '0; bus.r1_b = '0; bus.r1_cmd = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_rsp_valid", bus.rsp_valid, 0);
        check("reset_alu_a", bus.alu_a, 0);
        check("reset_rsp_result", bus.rsp_result, 0);
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(vecs[i]);

        // Asynchronous reset while r0's AND is in EXEC.
        drive(0, CMD_AND, 32'hF0F0F0F0, 32'hFF00FF00);
        @(negedge clk);
        bus.r0_valid = 1'b0;
        check("pre_reset_busy", busy, 1);
        check("pre_reset_alu_b", bus.alu_b, 32'hFF00FF00);
        #1 reset = 1'b1;
        #1;
        check("areset_busy", busy, 0);
        check("areset_alu_a", bus.alu_a, 0);
        check("areset_alu_b", bus.alu_b, 0);
        check("areset_alu_cmd", bus.alu_cmd, 0);
        check("areset_rsp_valid", bus.rsp_valid, 0);
        check("areset_rsp_id", bus.rsp_id, 0);
        check("areset_rsp_result", bus.rsp_result, 0);
        check("areset_flags", {bus.rsp_carryout, bus.rsp_zero, bus.rsp_overflow}, 0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_reset_no_rsp", bus.rsp_valid, 0);
            check("post_reset_idle", busy, 0);
        end

        // Both requesters held valid: grants alternate starting with RR_INIT=0.
        drive(0, CMD_SLT, 32'hFFFFFFFF, 32'h00000001);
        drive(1, CMD_NOR, 32'h00000000, 32'h00000000);
        for (int k = 0; k < 4; k++) begin
            #1;
            check("rr_r0_ready", bus.r0_ready, (k % 2 == 0));
            check("rr_r1_ready", bus.r1_ready, (k % 2 == 1));
            @(negedge clk);
            @(negedge clk);
            check("rr_rsp_valid", bus.rsp_valid, 1);
            check("rr_rsp_id", bus.rsp_id, k % 2);
            check("rr_rsp_result", bus.rsp_result, (k % 2 == 0) ? 32'h00000001 : 32'hFFFFFFFF);
            check("rr_flags", {bus.rsp_carryout, bus.rsp_zero, bus.rsp_overflow}, 0);
            $display("rr grant %0d id=%0d result=%h", k, bus.rsp_id, bus.rsp_result);
            @(negedge clk);
        end
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;

        // Consumer stalls 10 cycles in RESP with r1 waiting.
        bus.rsp_ready = 1'b0;
        drive(0, CMD_ADD, 32'd3, 32'd4);
        @(negedge clk);
        bus.r0_valid = 1'b0;
        drive(1, CMD_SUB, 32'd10, 32'd3);
        @(negedge clk);
        for (int s = 0; s < 10; s++) begin
            @(negedge clk);
            check("stall_rsp_valid", bus.rsp_valid, 1);
            check("stall_rsp_result", bus.rsp_result, 32'd7);
            check("stall_rsp_id", bus.rsp_id, 0);
            check("stall_readys", {bus.r0_ready, bus.r1_ready}, 0);
            check("stall_busy", busy, 1);
        end
        $display("stall released result=%h", bus.rsp_result);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("release_idle", busy, 0);

        // Only r1 valid, three times back to back.
        for (int j = 0; j < 3; j++) begin
            drive(1, CMD_SUB, 32'(10 - j), 32'd3);
            #1;
            check("r1only_ready", bus.r1_ready, 1);
            check("r1only_r0_ready", bus.r0_ready, 0);
            @(negedge clk);
            check("r1only_busy", busy, 1);
            @(negedge clk);
            check("r1only_rsp_id", bus.rsp_id, 1);
            check("r1only_result", bus.rsp_result, 32'(7 - j));
            check("r1only_carry", bus.rsp_carryout, 1);
            $display("r1 only op %0d result=%h", j, bus.rsp_result);
            @(negedge clk);
        end
        bus.r1_valid = 1'b0;

        // Priority now rests with r0.
        drive(0, CMD_ADD, 32'd1, 32'd1);
        drive(1, CMD_ADD, 32'd2, 32'd2);
        #1;
        check("final_prio_r0", bus.r0_ready, 1);
        check("final_prio_r1", bus.r1_ready, 0);
        bus.r0_valid = 1'b0;
        bus.r1_valid = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
